// File: rtl/example_combinational_checker.sv
// Stimulus/response checker for the 3-input/1-output example circuit: sweeps {a,b,c}, samples y, tallies mismatches.
// Optional build macro CHECKER_STOP_ON_FAIL_EN ends the sweep at the first mismatching vector.
module example_combinational_checker #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter logic [7:0]  EXPECT_TT     = 8'h21
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a_out,
  output logic       b_out,
  output logic       c_out,
  input  logic       y_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [7:0] fail_map
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [7:0] LP_SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  state_t     r_state;
  state_t     w_next;
  logic [2:0] r_idx;
  logic [7:0] r_cnt;
  logic [3:0] r_err;
  logic [7:0] r_fail;
  logic       w_accept;
  logic       w_settled;
  logic       w_mismatch;
  logic       w_last;

  assign w_accept   = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_settled  = (r_cnt == LP_SETTLE_LAST);
  assign w_mismatch = (y_in != EXPECT_TT[r_idx]);
`ifdef CHECKER_STOP_ON_FAIL_EN
  assign w_last     = (r_idx == 3'd7) || w_mismatch;
`else
  assign w_last     = (r_idx == 3'd7);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_SETTLE;
      S_SETTLE: if (w_settled) w_next = S_SAMPLE;
      S_SAMPLE: w_next = w_last ? S_DONE : S_SETTLE;
      S_DONE:   if (start) w_next = S_SETTLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // idx is left untouched on the final sample so a/b/c keep the last driven vector in DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx  <= 3'd0;
      r_cnt  <= 8'd0;
      r_err  <= 4'd0;
      r_fail <= 8'd0;
    end else if (w_accept) begin
      r_idx  <= 3'd0;
      r_cnt  <= 8'd0;
      r_err  <= 4'd0;
      r_fail <= 8'd0;
    end else if (r_state == S_SETTLE) begin
      r_cnt <= r_cnt + 8'd1;
    end else if (r_state == S_SAMPLE) begin
      if (w_mismatch) begin
        r_fail[r_idx] <= 1'b1;
        r_err         <= r_err + 4'd1;
      end
      if (!w_last) begin
        r_idx <= r_idx + 3'd1;
        r_cnt <= 8'd0;
      end
    end
  end

  assign a_out     = r_idx[2];
  assign b_out     = r_idx[1];
  assign c_out     = r_idx[0];
  assign busy      = (r_state == S_SETTLE) || (r_state == S_SAMPLE);
  assign done      = (r_state == S_DONE);
  assign pass      = done && (r_err == 4'd0);
  assign err_count = r_err;
  assign fail_map  = r_fail;

endmodule
